// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM encoding and address-mode helpers for the SPI RAM responder.
package spi_ram_pkg;

  localparam int MEM_AW_DEF = 10;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_SEQ   = 2'b01;
  localparam logic [1:0] MODE_PAGE  = 2'b10;
  localparam logic [7:0] MODE_RESET = 8'h40;

  // Page mode keeps the upper address bits and wraps inside a 32-byte page.
  function automatic logic [15:0] next_addr(input logic [15:0] addr, input logic [1:0] mode);
    if (mode == MODE_PAGE) begin
      next_addr = {addr[15:5], addr[4:0] + 5'd1};
    end else begin
      next_addr = addr + 16'd1;
    end
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins with registered SCK edge pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_n,
  output logic o_cs_fall,
  output logic o_mosi
);

  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_cs_meta, r_cs_sync, r_cs_prev;
  logic r_mosi_meta, r_mosi_sync;
  logic r_sck_rise, r_sck_fall;

  // Pipes keep tracking the pins through reset so release never shows a phantom edge.
  always_ff @(posedge clk) begin
    r_sck_meta  <= i_sck;
    r_sck_sync  <= r_sck_meta;
    r_sck_prev  <= r_sck_sync;
    r_cs_meta   <= i_cs_n;
    r_cs_sync   <= r_cs_meta;
    r_cs_prev   <= r_cs_sync;
    r_mosi_meta <= i_mosi;
    r_mosi_sync <= r_mosi_meta;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
    end else begin
      r_sck_rise <= r_sck_sync & ~r_sck_prev;
      r_sck_fall <= ~r_sck_sync & r_sck_prev;
    end
  end

  assign o_sck_rise = r_sck_rise;
  assign o_sck_fall = r_sck_fall;
  assign o_cs_n     = r_cs_sync;
  assign o_cs_fall  = r_cs_prev & ~r_cs_sync;
  assign o_mosi     = r_mosi_sync;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI-slave serial SRAM model (READ/WRITE with bursts) backed by internal block RAM.
// Optional SPI_RAM_STATUS_REG_EN adds RDSR/WRSR and byte/page/sequential modes.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCK,
  input  logic        CS_N,
  input  logic        MOSI,
  output logic        MISO,
  output logic        miso_oe,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  logic w_sck_rise, w_sck_fall, w_cs_n, w_cs_fall, w_mosi;

  spi_pin_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_sck      (SCK),
    .i_cs_n     (CS_N),
    .i_mosi     (MOSI),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_n     (w_cs_n),
    .o_cs_fall  (w_cs_fall),
    .o_mosi     (w_mosi)
  );

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_bit_cnt;
  logic [7:0]         r_shift, r_op, r_ram_q, w_shift_in;
  logic [15:0]        r_addr;
  logic [1:0]         r_rd_pipe;
  logic               r_miso, r_miso_oe, r_wr_strobe;
  logic [15:0]        r_wr_addr;
  logic [7:0]         r_wr_data;
  logic               w_byte_end, w_ram_we;
  logic [1:0]         w_mode;
  logic [MEM_AW-1:0]  w_ram_idx;
  logic [7:0]         r_mem [0:(1<<MEM_AW)-1];

`ifdef SPI_RAM_STATUS_REG_EN
  logic [7:0] r_mode;
  assign w_mode = r_mode[7:6];
`else
  assign w_mode = MODE_SEQ;
`endif

  assign w_shift_in = {r_shift[6:0], w_mosi};
  assign w_byte_end = w_sck_rise && (r_bit_cnt[2:0] == 3'd7);
  assign w_ram_idx  = r_addr[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a deasserted chip select overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    if (w_cs_n) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) w_state_nxt = ST_CMD;
          else           w_state_nxt = ST_IDLE;
        end
        ST_CMD: begin
          if (w_byte_end) begin
            case (w_shift_in)
              OP_READ, OP_WRITE: w_state_nxt = ST_ADDR;
`ifdef SPI_RAM_STATUS_REG_EN
              OP_RDSR:           w_state_nxt = ST_RDATA;
              OP_WRSR:           w_state_nxt = ST_WDATA;
`endif
              default:           w_state_nxt = ST_IGNORE;
            endcase
          end else begin
            w_state_nxt = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (w_sck_rise && r_bit_cnt == 5'd15) w_state_nxt = (r_op == OP_READ) ? ST_RDATA : ST_WDATA;
          else                                  w_state_nxt = ST_ADDR;
        end
        ST_WDATA: begin
          if (w_byte_end) begin
            w_ram_we = (r_op == OP_WRITE);
            if (r_op != OP_WRITE || w_mode == MODE_BYTE) w_state_nxt = ST_IGNORE;
            else                                         w_state_nxt = ST_WDATA;
          end else begin
            w_state_nxt = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (w_byte_end && r_op == OP_READ && w_mode == MODE_BYTE) w_state_nxt = ST_IGNORE;
          else                                                       w_state_nxt = ST_RDATA;
        end
        ST_IGNORE: w_state_nxt = ST_IGNORE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift/address datapath, read prefetch pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt   <= 5'd0;
      r_shift     <= 8'h00;
      r_op        <= 8'h00;
      r_addr      <= 16'h0000;
      r_rd_pipe   <= 2'b00;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 16'h0000;
      r_wr_data   <= 8'h00;
`ifdef SPI_RAM_STATUS_REG_EN
      r_mode      <= MODE_RESET;
`endif
    end else begin
      r_wr_strobe <= 1'b0;
      r_rd_pipe   <= {r_rd_pipe[0], 1'b0};
      if (w_state_nxt != r_state) r_bit_cnt <= 5'd0;
      else if (w_sck_rise)        r_bit_cnt <= r_bit_cnt + 5'd1;

      case (r_state)
        ST_CMD: begin
          if (w_sck_rise) begin
            r_shift <= w_shift_in;
            if (r_bit_cnt == 5'd7) begin
              r_op <= w_shift_in;
`ifdef SPI_RAM_STATUS_REG_EN
              if (w_shift_in == OP_RDSR) begin
                r_shift   <= {r_mode[6:0], 1'b0};
                r_miso    <= r_mode[7];
                r_miso_oe <= 1'b1;
              end
`endif
            end
          end
        end
        ST_ADDR: begin
          if (w_sck_rise) begin
            r_addr <= {r_addr[14:0], w_mosi};
            if (r_bit_cnt == 5'd15 && r_op == OP_READ) r_rd_pipe <= 2'b01;
          end
        end
        ST_WDATA: begin
          if (w_sck_rise) r_shift <= w_shift_in;
          if (w_ram_we) begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_wr_data   <= w_shift_in;
            r_addr      <= next_addr(r_addr, w_mode);
          end
`ifdef SPI_RAM_STATUS_REG_EN
          if (w_byte_end && r_op == OP_WRSR && !w_cs_n) r_mode <= w_shift_in;
`endif
        end
        ST_RDATA: begin
          if (w_byte_end) begin
            if (r_op == OP_READ) begin
              r_addr    <= next_addr(r_addr, w_mode);
              r_rd_pipe <= 2'b01;
            end
`ifdef SPI_RAM_STATUS_REG_EN
            else begin
              r_shift <= {r_mode[6:0], 1'b0};
              r_miso  <= r_mode[7];
            end
`endif
          end else if (w_sck_fall && r_bit_cnt[2:0] != 3'd0) begin
            // The fall right after a byte boundary keeps the freshly loaded MSB.
            r_miso  <= r_shift[7];
            r_shift <= {r_shift[6:0], 1'b0};
          end
        end
        default: ;
      endcase

      if (r_rd_pipe[1] && r_state == ST_RDATA && w_state_nxt == ST_RDATA) begin
        r_shift   <= {r_ram_q[6:0], 1'b0};
        r_miso    <= r_ram_q[7];
        r_miso_oe <= 1'b1;
      end
      if (w_state_nxt != ST_RDATA) begin
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end
    end
  end

  // Single-port byte RAM with registered read; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= w_shift_in;
    r_ram_q <= r_mem[w_ram_idx];
  end

  assign MISO      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI mode-0 master tasks, strobe log and assertions.
module tb_spi_ram_responder;

  logic        clk = 1'b0;
  logic        reset, SCK, CS_N, MOSI;
  logic        MISO, miso_oe, wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int quiet_bad = 0;
  logic quiet_en = 1'b0;
  logic [15:0] q_addr[$];
  logic [7:0]  q_data[$];

  always #5 clk = ~clk;

  spi_ram_responder #(.MEM_AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCK       (SCK),
    .CS_N      (CS_N),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .miso_oe   (miso_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always @(negedge clk) begin
    if (reset === 1'b1 && wr_strobe === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
    if (quiet_en && (MISO !== 1'b0 || miso_oe !== 1'b0)) quiet_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    MOSI = 1'b0;
    CS_N = 1'b0;
    #50;
  endtask

  task automatic spi_end();
    #50;
    CS_N = 1'b1;
    #100;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      MOSI = tx[i];
      #50;
      SCK = 1'b1;
      rx[i] = MISO;
      #50;
      SCK = 1'b0;
    end
  endtask

  task automatic spi_hdr(input logic [7:0] op, input logic [15:0] addr);
    logic [7:0] junk;
    spi_bits(op, 8, junk);
    spi_bits(addr[15:8], 8, junk);
    spi_bits(addr[7:0], 8, junk);
  endtask

  task automatic write_bytes(input logic [15:0] addr, input logic [31:0] data, input int n);
    logic [7:0] junk;
    spi_begin();
    spi_hdr(8'h02, addr);
    for (int i = 0; i < n; i++) spi_bits(data[31-8*i -: 8], 8, junk);
    spi_end();
  endtask

  task automatic read_bytes(input logic [15:0] addr, input int n, output logic [31:0] rd);
    logic [7:0] b;
    rd = 32'h0;
    spi_begin();
    spi_hdr(8'h03, addr);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, b);
      rd[31-8*i -: 8] = b;
    end
    spi_end();
  endtask

  logic [31:0] rd;
  logic [7:0]  rx, rx_or;
  logic [15:0] exp_a [4];
  logic [7:0]  exp_d [4];

  initial begin
    reset = 1'b0; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // single write then burst read
    q_addr.delete(); q_data.delete();
    write_bytes(16'h0012, 32'hA5000000, 1);
    check("w1_count", q_addr.size(), 32'd1);
    check("w1_addr", {16'd0, q_addr[0]}, 32'h0012);
    check("w1_data", {24'd0, q_data[0]}, 32'hA5);
    read_bytes(16'h0012, 4, rd);
    check("r1_byte0", {24'd0, rd[31:24]}, 32'hA5);
    check("r1_oe_after_cs", {31'd0, miso_oe}, 32'd0);

    // burst across the RAM depth boundary
    q_addr.delete(); q_data.delete();
    write_bytes(16'h03FE, 32'h11223344, 4);
    exp_a = '{16'h03FE, 16'h03FF, 16'h0400, 16'h0401};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("w2_count", q_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w2_addr%0d", i), {16'd0, q_addr[i]}, {16'd0, exp_a[i]});
      check($sformatf("w2_data%0d", i), {24'd0, q_data[i]}, {24'd0, exp_d[i]});
    end
    read_bytes(16'h0000, 2, rd);
    check("r2_wrap", {16'd0, rd[31:16]}, 32'h3344);
    read_bytes(16'h03FE, 2, rd);
    check("r2_top", {16'd0, rd[31:16]}, 32'h1122);

    // unknown opcode stays silent
    q_addr.delete(); q_data.delete();
    quiet_bad = 0; quiet_en = 1'b1; rx_or = 8'h00;
    spi_begin();
    spi_bits(8'h9F, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'hFF, 8, rx);
      rx_or = rx_or | rx;
    end
    spi_end();
`ifndef SPI_RAM_STATUS_REG_EN
    spi_begin();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, rx);
    rx_or = rx_or | rx;
    spi_end();
`endif
    quiet_en = 1'b0;
    check("ign_quiet", quiet_bad, 32'd0);
    check("ign_rx", {24'd0, rx_or}, 32'd0);
    check("ign_strobes", q_addr.size(), 32'd0);

    // partial write byte discarded
    write_bytes(16'h0020, 32'h5A000000, 1);
    q_addr.delete(); q_data.delete();
    spi_begin();
    spi_hdr(8'h02, 16'h0020);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    check("part_strobes", q_addr.size(), 32'd0);
    read_bytes(16'h0020, 1, rd);
    check("part_ram", {24'd0, rd[31:24]}, 32'h5A);

    // reset in the middle of a read burst
    q_addr.delete(); q_data.delete();
    spi_begin();
    spi_hdr(8'h03, 16'h03FE);
    spi_bits(8'h00, 8, rx);
    check("rr_byte0", {24'd0, rx}, 32'h11);
    check("rr_oe_before", {31'd0, miso_oe}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rr_miso", {31'd0, MISO}, 32'd0);
    check("rr_oe", {31'd0, miso_oe}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    quiet_bad = 0; quiet_en = 1'b1; rx_or = 8'h00;
    for (int i = 0; i < 2; i++) begin
      spi_bits(8'hFF, 8, rx);
      rx_or = rx_or | rx;
    end
    spi_end();
    quiet_en = 1'b0;
    check("rr_quiet", quiet_bad, 32'd0);
    check("rr_rx", {24'd0, rx_or}, 32'd0);
    check("rr_strobes", q_addr.size(), 32'd0);
    read_bytes(16'h03FE, 2, rd);
    check("rr_next_frame", {16'd0, rd[31:16]}, 32'h1122);

    // 16-bit address wrap
    q_addr.delete(); q_data.delete();
    write_bytes(16'hFFFF, 32'h77880000, 2);
    check("aw_count", q_addr.size(), 32'd2);
    check("aw_addr0", {16'd0, q_addr[0]}, 32'hFFFF);
    check("aw_addr1", {16'd0, q_addr[1]}, 32'h0000);
    check("aw_data1", {24'd0, q_data[1]}, 32'h88);
    read_bytes(16'h03FF, 2, rd);
    check("aw_read", {16'd0, rd[31:16]}, 32'h7788);

`ifdef SPI_RAM_STATUS_REG_EN
    spi_begin();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, rx);
    check("rdsr_0", {24'd0, rx}, 32'h40);
    spi_bits(8'h00, 8, rx);
    check("rdsr_1", {24'd0, rx}, 32'h40);
    spi_end();
    spi_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_end();
    q_addr.delete(); q_data.delete();
    write_bytes(16'h001F, 32'hAABB0000, 2);
    check("page_addr0", {16'd0, q_addr[0]}, 32'h001F);
    check("page_addr1", {16'd0, q_addr[1]}, 32'h0000);
    read_bytes(16'h0000, 1, rd);
    check("page_ram0", {24'd0, rd[31:24]}, 32'hBB);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
